// File: rtl/lfsr_arb_pkg.sv
// Shared types and helpers for the LFSR bit arbiter: FSM state type,
// default maximal-length tap masks and the single-step LFSR function.
package lfsr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int LFSR_MAX_W = 16;

    // Tap masks use bit (k-1) for polynomial term x^k, matching the left-shift step.
    localparam logic [15:0] TAPS_W4  = 16'h000C;
    localparam logic [15:0] TAPS_W5  = 16'h0014;
    localparam logic [15:0] TAPS_W6  = 16'h0030;
    localparam logic [15:0] TAPS_W7  = 16'h0060;
    localparam logic [15:0] TAPS_W8  = 16'h00B8;
    localparam logic [15:0] TAPS_W9  = 16'h0110;
    localparam logic [15:0] TAPS_W10 = 16'h0240;
    localparam logic [15:0] TAPS_W11 = 16'h0500;
    localparam logic [15:0] TAPS_W12 = 16'h0E08;
    localparam logic [15:0] TAPS_W13 = 16'h1C80;
    localparam logic [15:0] TAPS_W14 = 16'h3802;
    localparam logic [15:0] TAPS_W15 = 16'h6000;
    localparam logic [15:0] TAPS_W16 = 16'hD008;

    function automatic logic [15:0] default_taps(input int w);
        case (w)
            4:       return TAPS_W4;
            5:       return TAPS_W5;
            6:       return TAPS_W6;
            7:       return TAPS_W7;
            8:       return TAPS_W8;
            9:       return TAPS_W9;
            10:      return TAPS_W10;
            11:      return TAPS_W11;
            12:      return TAPS_W12;
            13:      return TAPS_W13;
            14:      return TAPS_W14;
            15:      return TAPS_W15;
            default: return TAPS_W16;
        endcase
    endfunction

    // Callers zero-extend narrower states; bits above their width are discarded.
    function automatic logic [15:0] next_lfsr(input logic [15:0] state, input logic [15:0] taps);
        return {state[14:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register that can never hold zero: a zero seed loads as 1.
module lfsr_core
    import lfsr_arb_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] TAPS = 8'hB8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] state
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_next;
    logic [W-1:0] w_load_fixed;

    assign w_next       = W'(next_lfsr(16'(r_state), 16'(TAPS)));
    assign w_load_fixed = (load_val == '0) ? W'(1) : load_val;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= W'(1);
        end else if (load) begin
            r_state <= w_load_fixed;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_bit_arbiter.sv
// Round-robin arbiter sharing one LFSR among N requesters; each grant yields
// a registered Bernoulli bit (lfsr <= prob) tagged with the winner's index.
module lfsr_bit_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int           N    = 4,
    parameter int           W    = 8,
    parameter logic [W-1:0] TAPS = 8'hB8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   seed_valid,
    input  logic [W-1:0]           seed,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         prob,
    output logic [N-1:0]           gnt,
    output logic                   bit_valid,
    output logic                   bit_out,
    output logic [$clog2(N)-1:0]   bit_id
);

    localparam int IDW = $clog2(N);

    state_e         r_state;
    state_e         w_next_state;
    logic [W-1:0]   r_seed;
    logic [W-1:0]   w_lfsr;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_idx;
    int             w_sum;
    logic           w_found;
    logic           w_load;
    logic           w_grant;
    logic [W-1:0]   w_win_prob;
    logic [N-1:0]   r_gnt;
    logic           r_bit_valid;
    logic           r_bit_out;
    logic [IDW-1:0] r_bit_id;

    lfsr_core #(
        .W    (W),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (w_load),
        .load_val (r_seed),
        .step     (w_grant),
        .state    (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (seed_valid) w_next_state = LOAD;
            LOAD:    w_next_state = RUN;
            RUN:     if (seed_valid) w_next_state = LOAD;
            default: w_next_state = IDLE;
        endcase
    end

    // A seed request in RUN pre-empts arbitration for that cycle.
    always_comb begin
        w_load  = (r_state == LOAD);
        w_grant = (r_state == RUN) && !seed_valid && w_found;
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= N) w_sum = w_sum - N;
            w_idx = IDW'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_prob = '0;
        for (int i = 0; i < N; i++) begin
            if (w_winner == IDW'(i)) w_win_prob = prob[i*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_seed <= '0;
        end else if (seed_valid && r_state != LOAD) begin
            r_seed <= seed;
        end
    end

    // bit_out/bit_id deliberately hold their last value when no grant is made.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_gnt       <= '0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant) begin
            r_gnt       <= N'(1) << w_winner;
            r_bit_valid <= 1'b1;
            r_bit_out   <= (w_lfsr <= w_win_prob);
            r_bit_id    <= w_winner;
            r_rr_ptr    <= (w_winner == IDW'(N-1)) ? '0 : w_winner + IDW'(1);
        end else begin
            r_gnt       <= '0;
            r_bit_valid <= 1'b0;
        end
    end

    assign gnt       = r_gnt;
    assign bit_valid = r_bit_valid;
    assign bit_out   = r_bit_out;
    assign bit_id    = r_bit_id;

endmodule

// File: tb/tb_lfsr_bit_arbiter.sv
// Self-checking bench for lfsr_bit_arbiter: a behavioural model checked every
// cycle, directed scenarios with hand-computed expectations, then random traffic.
module tb_lfsr_bit_arbiter;
    import lfsr_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        seed_valid = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  pv [4];
    logic [31:0] prob;
    logic [3:0]  gnt;
    logic        bit_valid;
    logic        bit_out;
    logic [1:0]  bit_id;

    int checks = 0;
    int errors = 0;

    assign prob = {pv[3], pv[2], pv[1], pv[0]};

    always #5 clk = ~clk;

    lfsr_bit_arbiter #(
        .N    (N),
        .W    (W),
        .TAPS (8'hB8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .seed_valid (seed_valid),
        .seed       (seed),
        .req        (req),
        .prob       (prob),
        .gnt        (gnt),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .bit_id     (bit_id)
    );

    // Model state: mode 0 = waiting for seed, 1 = loading, 2 = running.
    bit         m_init = 1'b0;
    int         m_mode;
    logic [7:0] m_lfsr;
    logic [7:0] m_seedcap;
    int         m_rr;
    logic [3:0] m_gnt;
    logic       m_valid;
    logic       m_bit;
    int         m_id;
    int         m_grants [4];
    int         d_ones [4];
    int         d_grants [4];

    function automatic logic [7:0] stepLfsr(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: decides the next registered outputs from sampled inputs.
    always @(posedge clk) begin
        int w;
        if (!rst_b) begin
            m_init  = 1'b1;
            m_mode  = 0;
            m_lfsr  = 8'h01;
            m_rr    = 0;
            m_gnt   = 4'b0000;
            m_valid = 1'b0;
            m_bit   = 1'b0;
            m_id    = 0;
        end else if (m_mode == 0) begin
            m_gnt   = 4'b0000;
            m_valid = 1'b0;
            if (seed_valid) begin
                m_seedcap = seed;
                m_mode    = 1;
            end
        end else if (m_mode == 1) begin
            m_gnt   = 4'b0000;
            m_valid = 1'b0;
            m_lfsr  = (m_seedcap == 8'h00) ? 8'h01 : m_seedcap;
            m_mode  = 2;
        end else if (seed_valid) begin
            m_gnt     = 4'b0000;
            m_valid   = 1'b0;
            m_seedcap = seed;
            m_mode    = 1;
        end else if (req != 4'b0000) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
            m_gnt   = 4'b0000;
            m_gnt[w] = 1'b1;
            m_valid = 1'b1;
            m_id    = w;
            m_bit   = (m_lfsr <= pv[w]);
            m_lfsr  = stepLfsr(m_lfsr);
            m_rr    = (w + 1) % N;
            m_grants[w]++;
        end else begin
            m_gnt   = 4'b0000;
            m_valid = 1'b0;
        end
    end

    // Compare the DUT against the model on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("gnt", int'(gnt), int'(m_gnt));
            checkOutput("bit_valid", int'(bit_valid), int'(m_valid));
            checkOutput("bit_out", int'(bit_out), int'(m_bit));
            checkOutput("bit_id", int'(bit_id), m_id);
            checkOutput("lfsr", int'(dut.w_lfsr), int'(m_lfsr));
            if (bit_valid) begin
                d_grants[bit_id]++;
                if (bit_out) d_ones[bit_id]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_b      = 1'b0;
        seed_valid = 1'b0;
        req        = 4'b0000;
        tick(2);
        rst_b = 1'b1;
    endtask

    task automatic doSeed(input logic [7:0] v);
        seed       = v;
        seed_valid = 1'b1;
        tick(1);
        seed_valid = 1'b0;
    endtask

    // Waits (bounded) until the model has issued n more grants to requester idx.
    task automatic waitGrants(input int idx, input int n);
        int target;
        int c;
        target = m_grants[idx] + n;
        c = 0;
        while (m_grants[idx] < target && c < 2000) begin
            tick(1);
            c++;
        end
        checkOutput("grant_timeout", m_grants[idx], target);
    endtask

    // Random requester traffic obeying the hold-until-granted handshake.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (req[i] && m_gnt[i]) begin
                req[i] = 1'($urandom_range(0, 1));
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                case ($urandom_range(0, 5))
                    0:       pv[i] = 8'h00;
                    1:       pv[i] = 8'hFF;
                    default: pv[i] = 8'($urandom);
                endcase
            end
        end
        seed_valid = ($urandom_range(0, 39) == 0);
        seed       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        rst_b      = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_ones;
        int base_grants;
        int found;
        logic [7:0] exp_lfsr;
        int rr_ids [3];
        logic [3:0] rr_gnts [3];

        rr_ids  = '{0, 1, 3};
        rr_gnts = '{4'b0001, 4'b0010, 4'b1000};
        for (int i = 0; i < N; i++) begin
            pv[i]       = 8'h80;
            m_grants[i] = 0;
            d_ones[i]   = 0;
            d_grants[i] = 0;
        end

        // Reset then requests with no seed: nothing may be granted.
        tick(2);
        rst_b = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_gnt", int'(gnt), 0);
            checkOutput("idle_valid", int'(bit_valid), 0);
        end
        checkOutput("idle_lfsr", int'(dut.w_lfsr), 1);
        @(posedge clk);
        #1;

        // Seeding latency: first bit two edges after the seed is sampled.
        doReset();
        pv[0] = 8'h50;
        req   = 4'b0001;
        seed  = 8'h4F;
        seed_valid = 1'b1;
        tick(1);
        seed_valid = 1'b0;
        @(negedge clk);
        checkOutput("seed_lat1_valid", int'(bit_valid), 0);
        @(negedge clk);
        checkOutput("seed_lat2_valid", int'(bit_valid), 0);
        @(negedge clk);
        checkOutput("seed_first_valid", int'(bit_valid), 1);
        checkOutput("seed_first_id", int'(bit_id), 0);
        checkOutput("seed_first_bit", int'(bit_out), 1);
        @(posedge clk);
        #1;
        req = 4'b0000;

        // Exact density over one full period from seed 1.
        doReset();
        pv[0] = 8'hAA;
        req   = 4'b0001;
        base_ones   = d_ones[0];
        base_grants = d_grants[0];
        doSeed(8'h01);
        waitGrants(0, 255);
        req = 4'b0000;
        tick(2);
        checkOutput("density_ones", d_ones[0] - base_ones, 170);
        checkOutput("density_grants", d_grants[0] - base_grants, 255);
        checkOutput("density_lfsr_wrap", int'(dut.w_lfsr), 1);

        // Extreme probabilities.
        doReset();
        pv[1] = 8'h00;
        pv[2] = 8'hFF;
        req   = 4'b0010;
        base_ones = d_ones[1];
        doSeed(8'h9C);
        waitGrants(1, 255);
        req = 4'b0000;
        tick(2);
        checkOutput("prob_zero_ones", d_ones[1] - base_ones, 0);
        base_ones = d_ones[2];
        req = 4'b0100;
        waitGrants(2, 255);
        req = 4'b0000;
        tick(2);
        checkOutput("prob_full_ones", d_ones[2] - base_ones, 255);

        // Round-robin among requesters 0, 1 and 3.
        doReset();
        for (int i = 0; i < N; i++) pv[i] = 8'($urandom);
        req = 4'b1011;
        doSeed(8'h5A);
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (bit_valid) found = 1;
        end
        checkOutput("rr_start_seen", found, 1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("rr_bit_id", int'(bit_id), rr_ids[i % 3]);
            checkOutput("rr_gnt_onehot", int'(gnt), int'(rr_gnts[i % 3]));
        end
        exp_lfsr = 8'h5A;
        repeat (12) exp_lfsr = stepLfsr(exp_lfsr);
        checkOutput("rr_lfsr_12_steps", int'(dut.w_lfsr), int'(exp_lfsr));

        // Reset while grants are flowing.
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        tick(1);
        rst_b = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        checkOutput("rst_mid_gnt", int'(gnt), 0);
        checkOutput("rst_mid_valid", int'(bit_valid), 0);
        checkOutput("rst_mid_state", int'(dut.r_state), int'(IDLE));
        checkOutput("rst_mid_lfsr", int'(dut.w_lfsr), 1);
        @(posedge clk);
        #1;

        // Reseed with zero while running: seed wins, lfsr holds, then loads 1.
        doReset();
        pv[0] = 8'h40;
        req   = 4'b0001;
        doSeed(8'h33);
        waitGrants(0, 5);
        exp_lfsr = 8'h33;
        repeat (5) exp_lfsr = stepLfsr(exp_lfsr);
        seed       = 8'h00;
        seed_valid = 1'b1;
        tick(1);
        seed_valid = 1'b0;
        @(negedge clk);
        checkOutput("reseed_no_gnt", int'(gnt), 0);
        checkOutput("reseed_lfsr_hold", int'(dut.w_lfsr), int'(exp_lfsr));
        @(negedge clk);
        checkOutput("reseed_zero_lfsr", int'(dut.w_lfsr), 1);
        @(negedge clk);
        checkOutput("reseed_regrant", int'(bit_valid), 1);
        @(posedge clk);
        #1;
        req = 4'b0000;

        // Random traffic with occasional seeds and resets.
        doReset();
        doSeed(8'($urandom));
        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            tick(1);
        end
        rst_b      = 1'b1;
        seed_valid = 1'b0;
        req        = 4'b0000;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
